// File: rtl/game_gfx_pkg.sv
// Shared graphics constants and helpers for the display path (RGB332 pixels).
package game_gfx_pkg;

  localparam int GFX_PIX_W = 8;

  // RGB332 field positions inside a pixel: {R[2:0], G[2:0], B[1:0]}
  localparam int R_MSB = 7;
  localparam int R_LSB = 5;
  localparam int G_MSB = 4;
  localparam int G_LSB = 2;
  localparam int B_MSB = 1;
  localparam int B_LSB = 0;

  // Assemble an RGB332 pixel from its colour fields.
  function automatic logic [GFX_PIX_W-1:0] rgb332_pack(input logic [2:0] r,
                                                       input logic [2:0] g,
                                                       input logic [1:0] b);
    logic [GFX_PIX_W-1:0] p;
    p = '0;
    p[R_MSB:R_LSB] = r;
    p[G_MSB:G_LSB] = g;
    p[B_MSB:B_LSB] = b;
    return p;
  endfunction

  // Colour key that lets lower-priority layers show through.
  localparam logic [GFX_PIX_W-1:0] GFX_TRANSP = 8'h00;
  // Grey drawn outside the play window.
  localparam logic [GFX_PIX_W-1:0] GFX_BORDER = rgb332_pack(3'b100, 3'b100, 2'b10);

endpackage

// File: rtl/sprite_hit_addr.sv
// One sprite channel: rectangle hit test and linear ROM address, registered.
module sprite_hit_addr #(
  parameter int COORD_W = 10,
  parameter int ADDR_W  = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] i_hc,
  input  logic [COORD_W-1:0] i_vc,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic [COORD_W-1:0] i_w,
  input  logic [COORD_W-1:0] i_h,
  input  logic               i_en,
  input  logic               i_anim,
  output logic               o_hit,
  output logic [ADDR_W-1:0]  o_addr
);

  // Right/bottom limits carry one extra bit so a sprite near the edge never wraps to column 0.
  logic [COORD_W:0]  w_x_end;
  logic [COORD_W:0]  w_y_end;
  logic              w_hit;
  logic [COORD_W-1:0] w_dx;
  logic [COORD_W-1:0] w_dy;
  logic [ADDR_W-1:0] w_frame_off;
  logic [ADDR_W-1:0] w_lin;
  logic              r_hit;
  logic [ADDR_W-1:0] r_addr;

  assign w_x_end = {1'b0, i_x} + {1'b0, i_w};
  assign w_y_end = {1'b0, i_y} + {1'b0, i_h};

  assign w_hit = i_en && (i_w != '0) && (i_h != '0) &&
                 (i_hc >= i_x) && ({1'b0, i_hc} < w_x_end) &&
                 (i_vc >= i_y) && ({1'b0, i_vc} < w_y_end);

  assign w_dx = i_hc - i_x;
  assign w_dy = i_vc - i_y;

  // Address arithmetic is done modulo 2^ADDR_W, which equals truncating the full result.
  assign w_frame_off = i_anim ? (ADDR_W'(i_w) * ADDR_W'(i_h)) : '0;
  assign w_lin       = ADDR_W'(w_dx) + ADDR_W'(w_dy) * ADDR_W'(i_w) + w_frame_off;

  // Register hit flag and address; address is forced to 0 on a miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit  <= 1'b0;
      r_addr <= '0;
    end else begin
      r_hit  <= w_hit;
      r_addr <= w_hit ? w_lin : '0;
    end
  end

  assign o_hit  = r_hit;
  assign o_addr = r_addr;

endmodule

// File: rtl/sprite_compositor.sv
// Composes NUM_SPR prioritised sprites over a background pixel, with per-frame
// geometry latching and sprite-0 collision reporting.
module sprite_compositor
  import game_gfx_pkg::*;
#(
  parameter int NUM_SPR = 8,
  parameter int COORD_W = 10,
  parameter int ADDR_W  = 15,
  parameter int PIX_W   = GFX_PIX_W,
  parameter int ROM_LAT = 1,
  parameter logic [PIX_W-1:0] TRANSP = GFX_TRANSP,
  parameter logic [PIX_W-1:0] BORDER = GFX_BORDER
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_video_on,
  input  logic [COORD_W-1:0]         i_hc,
  input  logic [COORD_W-1:0]         i_vc,
  input  logic [COORD_W-1:0]         i_win_x0,
  input  logic [COORD_W-1:0]         i_win_x1,
  input  logic [COORD_W-1:0]         i_win_y0,
  input  logic [COORD_W-1:0]         i_win_y1,
  input  logic [NUM_SPR*COORD_W-1:0] i_spr_x,
  input  logic [NUM_SPR*COORD_W-1:0] i_spr_y,
  input  logic [NUM_SPR*COORD_W-1:0] i_spr_w,
  input  logic [NUM_SPR*COORD_W-1:0] i_spr_h,
  input  logic [NUM_SPR-1:0]         i_spr_en,
  input  logic [NUM_SPR-1:0]         i_spr_anim,
  output logic [NUM_SPR*ADDR_W-1:0]  o_rom_addr,
  input  logic [NUM_SPR*PIX_W-1:0]   i_rom_data,
  input  logic [PIX_W-1:0]           i_bg_pix,
  output logic [PIX_W-1:0]           o_rgb,
  output logic [NUM_SPR-2:0]         o_coll,
  output logic                       o_frame_done
);

  // Delay-line word: {hit[], in_win, video_on, bg_pix}
  localparam int DW = NUM_SPR + 2 + PIX_W;

  logic               w_latch;
  logic               w_in_win;
  logic [NUM_SPR-1:0] w_hit_s0;
  logic               r_in_win_s0;
  logic               r_von_s0;
  logic [PIX_W-1:0]   r_bg_s0;
  logic [DW-1:0]      r_dly [ROM_LAT];

  logic [NUM_SPR-1:0] w_hit_f;
  logic               w_win_f;
  logic               w_von_f;
  logic [PIX_W-1:0]   w_bg_f;
  logic [NUM_SPR-1:0] w_opaque;
  logic [NUM_SPR-2:0] w_coll_now;
  logic [PIX_W-1:0]   w_pix_sel;
  logic [PIX_W-1:0]   w_rgb_next;

  logic [PIX_W-1:0]   r_rgb;
  logic [NUM_SPR-2:0] r_coll;
  logic [NUM_SPR-2:0] r_acc;
  logic               r_frame_done;

  assign w_latch  = (i_hc == '0) && (i_vc == '0);
  assign w_in_win = (i_hc >= i_win_x0) && (i_hc < i_win_x1) &&
                    (i_vc >= i_win_y0) && (i_vc < i_win_y1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SPR; gi++) begin : g_spr
      logic [COORD_W-1:0] r_x, r_y, r_w, r_h;
      logic               r_en, r_anim;
      logic [COORD_W-1:0] w_x, w_y, w_w, w_h;
      logic               w_en, w_anim;

      // Shadow geometry, refreshed only at the top-left pixel so a frame never tears.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_x    <= '0;
          r_y    <= '0;
          r_w    <= '0;
          r_h    <= '0;
          r_en   <= 1'b0;
          r_anim <= 1'b0;
        end else if (w_latch) begin
          r_x    <= i_spr_x[gi*COORD_W +: COORD_W];
          r_y    <= i_spr_y[gi*COORD_W +: COORD_W];
          r_w    <= i_spr_w[gi*COORD_W +: COORD_W];
          r_h    <= i_spr_h[gi*COORD_W +: COORD_W];
          r_en   <= i_spr_en[gi];
          r_anim <= i_spr_anim[gi];
        end
      end

      // The latch pixel itself already sees the new frame's geometry.
      assign w_x    = w_latch ? i_spr_x[gi*COORD_W +: COORD_W] : r_x;
      assign w_y    = w_latch ? i_spr_y[gi*COORD_W +: COORD_W] : r_y;
      assign w_w    = w_latch ? i_spr_w[gi*COORD_W +: COORD_W] : r_w;
      assign w_h    = w_latch ? i_spr_h[gi*COORD_W +: COORD_W] : r_h;
      assign w_en   = w_latch ? i_spr_en[gi]   : r_en;
      assign w_anim = w_latch ? i_spr_anim[gi] : r_anim;

      sprite_hit_addr #(
        .COORD_W (COORD_W),
        .ADDR_W  (ADDR_W)
      ) u_hit (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_hc   (i_hc),
        .i_vc   (i_vc),
        .i_x    (w_x),
        .i_y    (w_y),
        .i_w    (w_w),
        .i_h    (w_h),
        .i_en   (w_en),
        .i_anim (w_anim),
        .o_hit  (w_hit_s0[gi]),
        .o_addr (o_rom_addr[gi*ADDR_W +: ADDR_W])
      );

      assign w_opaque[gi] = w_hit_f[gi] && (i_rom_data[gi*PIX_W +: PIX_W] != TRANSP);
    end
  endgenerate

  // Stage 0 side-band: window flag, video enable and background travel with the hit flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_win_s0 <= 1'b0;
      r_von_s0    <= 1'b0;
      r_bg_s0     <= '0;
    end else begin
      r_in_win_s0 <= w_in_win;
      r_von_s0    <= i_video_on;
      r_bg_s0     <= i_bg_pix;
    end
  end

  generate
    for (gi = 0; gi < ROM_LAT; gi++) begin : g_dly
      if (gi == 0) begin : g_first
        // First tap of the ROM-latency delay line.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) r_dly[gi] <= '0;
          else        r_dly[gi] <= {w_hit_s0, r_in_win_s0, r_von_s0, r_bg_s0};
        end
      end else begin : g_next
        // Further taps shift the word along to match deeper ROM latency.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) r_dly[gi] <= '0;
          else        r_dly[gi] <= r_dly[gi-1];
        end
      end
    end
  endgenerate

  assign {w_hit_f, w_win_f, w_von_f, w_bg_f} = r_dly[ROM_LAT-1];

  // Only sprite 0 against each other sprite is tracked.
  assign w_coll_now = {(NUM_SPR-1){w_opaque[0]}} & w_opaque[NUM_SPR-1:1];

  // Priority mux: lowest-index opaque sprite wins, then blanking and border override.
  always_comb begin
    w_pix_sel = w_bg_f;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (w_opaque[i]) w_pix_sel = i_rom_data[i*PIX_W +: PIX_W];
    end
    if (!w_von_f)      w_rgb_next = '0;
    else if (!w_win_f) w_rgb_next = BORDER;
    else               w_rgb_next = w_pix_sel;
  end

  // Output pixel, collision accumulator and frame report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb        <= '0;
      r_coll       <= '0;
      r_acc        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_rgb        <= w_rgb_next;
      r_frame_done <= w_latch;
      if (w_latch) begin
        r_coll <= r_acc;
        r_acc  <= w_coll_now;  // a hit on the latch clock belongs to the new frame
      end else begin
        r_acc  <= r_acc | w_coll_now;
      end
    end
  end

  assign o_rgb        = r_rgb;
  assign o_coll       = r_coll;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor with a behavioural ROM per sprite channel.
module tb_sprite_compositor;

  localparam int N  = 8;
  localparam int CW = 10;
  localparam int AW = 15;
  localparam int PW = 8;
  localparam logic [PW-1:0] BORDER_C = 8'b10010010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic video_on;
  logic [CW-1:0] hc, vc, wx0, wx1, wy0, wy1;
  logic [CW-1:0] sx [N];
  logic [CW-1:0] sy [N];
  logic [CW-1:0] sw [N];
  logic [CW-1:0] sh [N];
  logic [N-1:0]  sen, sanim;
  logic [N*CW-1:0] spr_x, spr_y, spr_w, spr_h;
  logic [N*AW-1:0] rom_addr;
  logic [N*PW-1:0] rom_data = '0;
  logic [PW-1:0]   bg, rgb;
  logic [N-2:0]    coll;
  logic            frame_done;
  logic [PW-1:0]   rom_const [N];
  logic            rom_use_addr [N];

  int errors;
  int checks;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      spr_x[i*CW +: CW] = sx[i];
      spr_y[i*CW +: CW] = sy[i];
      spr_w[i*CW +: CW] = sw[i];
      spr_h[i*CW +: CW] = sh[i];
    end
  end

  // ROM model, one clock of latency: either address LSBs or a constant colour.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      rom_data[i*PW +: PW] <= rom_use_addr[i] ? rom_addr[i*AW +: PW] : rom_const[i];
  end

  sprite_compositor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_video_on   (video_on),
    .i_hc         (hc),
    .i_vc         (vc),
    .i_win_x0     (wx0),
    .i_win_x1     (wx1),
    .i_win_y0     (wy0),
    .i_win_y1     (wy1),
    .i_spr_x      (spr_x),
    .i_spr_y      (spr_y),
    .i_spr_w      (spr_w),
    .i_spr_h      (spr_h),
    .i_spr_en     (sen),
    .i_spr_anim   (sanim),
    .o_rom_addr   (rom_addr),
    .i_rom_data   (rom_data),
    .i_bg_pix     (bg),
    .o_rgb        (rgb),
    .o_coll       (coll),
    .o_frame_done (frame_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int h, input int v, input logic [PW-1:0] b);
    hc = CW'(h);
    vc = CW'(v);
    bg = b;
  endtask

  task automatic set_fill();
    set_pix(600, 400, 8'h55);
  endtask

  task automatic set_spr(input int i, input int x, input int y, input int w, input int h,
                         input logic en);
    sx[i]  = CW'(x);
    sy[i]  = CW'(y);
    sw[i]  = CW'(w);
    sh[i]  = CW'(h);
    sen[i] = en;
  endtask

  // Present one pixel then flush; on return rgb holds that pixel's result.
  task automatic run_pixel(input int h, input int v, input logic [PW-1:0] b);
    set_pix(h, v, b);
    tick();
    set_fill();
    tick();
    tick();
  endtask

  task automatic test_reset();
    set_spr(0, 200, 100, 30, 37, 1'b1);
    rst_n = 1'b0;
    set_pix(215, 110, 8'hAA);
    repeat (3) tick();
    checks++; if (rgb !== 8'h00) begin errors++; $display("FAIL reset_rgb: got %h want 00", rgb); end
    else $display("ok reset_rgb %h", rgb);
    checks++; if (coll !== 7'b0) begin errors++; $display("FAIL reset_coll: got %b want 0", coll); end
    else $display("ok reset_coll %b", coll);
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b want 0", frame_done); end
    else $display("ok reset_fd %b", frame_done);
    checks++; if (rom_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", rom_addr); end
    else $display("ok reset_addr 0");
    rst_n = 1'b1;
    tick();
    checks++; if (rom_addr !== '0) begin errors++; $display("FAIL reset_hidden: got %h want 0", rom_addr); end
    else $display("ok reset_hidden 0");
  endtask

  task automatic test_basic();
    rom_use_addr[0] = 1'b1;
    set_pix(0, 0, 8'h55);
    tick();
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL basic_fd: got %b want 1", frame_done); end
    else $display("ok basic_fd");
    checks++; if (coll !== 7'b0) begin errors++; $display("FAIL basic_coll: got %b want 0", coll); end
    else $display("ok basic_coll");
    set_fill();
    tick();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL basic_fd_pulse: got %b want 0", frame_done); end
    else $display("ok basic_fd_pulse");
    set_pix(215, 110, 8'hAA);
    tick();
    checks++; if (rom_addr[AW-1:0] !== 15'd315) begin errors++; $display("FAIL basic_addr: got %0d want 315", rom_addr[AW-1:0]); end
    else $display("ok basic_addr 315");
    set_pix(229, 110, 8'hAA);
    tick();
    checks++; if (rgb !== 8'h55) begin errors++; $display("FAIL basic_latency: got %h want 55", rgb); end
    else $display("ok basic_latency");
    checks++; if (rom_addr[AW-1:0] !== 15'd329) begin errors++; $display("FAIL basic_addr_last: got %0d want 329", rom_addr[AW-1:0]); end
    else $display("ok basic_addr_last 329");
    set_pix(230, 110, 8'hAA);
    tick();
    checks++; if (rgb !== 8'h3B) begin errors++; $display("FAIL basic_rgb: got %h want 3b", rgb); end
    else $display("ok basic_rgb 3b");
    checks++; if (rom_addr[AW-1:0] !== 15'd0) begin errors++; $display("FAIL basic_edge_addr: got %0d want 0", rom_addr[AW-1:0]); end
    else $display("ok basic_edge_addr 0");
    set_fill();
    tick();
    checks++; if (rgb !== 8'h49) begin errors++; $display("FAIL basic_rgb_last: got %h want 49", rgb); end
    else $display("ok basic_rgb_last 49");
    tick();
    checks++; if (rgb !== 8'hAA) begin errors++; $display("FAIL basic_edge_bg: got %h want aa", rgb); end
    else $display("ok basic_edge_bg aa");
  endtask

  task automatic test_anim();
    sanim[0] = 1'b1;
    set_pix(215, 110, 8'hAA);
    tick();
    checks++; if (rom_addr[AW-1:0] !== 15'd315) begin errors++; $display("FAIL anim_midframe: got %0d want 315", rom_addr[AW-1:0]); end
    else $display("ok anim_midframe 315");
    set_pix(0, 0, 8'h55);
    tick();
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL anim_fd: got %b want 1", frame_done); end
    else $display("ok anim_fd");
    set_pix(215, 110, 8'hAA);
    tick();
    checks++; if (rom_addr[AW-1:0] !== 15'd1425) begin errors++; $display("FAIL anim_addr: got %0d want 1425", rom_addr[AW-1:0]); end
    else $display("ok anim_addr 1425");
    set_fill();
    tick();
    tick();
    checks++; if (rgb !== 8'h91) begin errors++; $display("FAIL anim_rgb: got %h want 91", rgb); end
    else $display("ok anim_rgb 91");
    sanim[0] = 1'b0;
  endtask

  task automatic test_priority();
    set_spr(1, 200, 100, 30, 37, 1'b1);
    rom_use_addr[0] = 1'b0;
    rom_const[0] = 8'hE0;
    rom_const[1] = 8'h1C;
    set_pix(0, 0, 8'h55);
    tick();
    run_pixel(210, 105, 8'hAA);
    checks++; if (rgb !== 8'hE0) begin errors++; $display("FAIL prio_s0: got %h want e0", rgb); end
    else $display("ok prio_s0 e0");
    rom_const[0] = 8'h00;
    run_pixel(210, 105, 8'hAA);
    checks++; if (rgb !== 8'h1C) begin errors++; $display("FAIL prio_transp0: got %h want 1c", rgb); end
    else $display("ok prio_transp0 1c");
    rom_const[1] = 8'h00;
    run_pixel(210, 105, 8'hAA);
    checks++; if (rgb !== 8'hAA) begin errors++; $display("FAIL prio_both_transp: got %h want aa", rgb); end
    else $display("ok prio_both_transp aa");
    rom_const[0] = 8'hE0;
    rom_const[1] = 8'h1C;
  endtask

  task automatic test_collision();
    sen[1] = 1'b0;
    set_spr(0, 290, 195, 30, 37, 1'b1);
    set_spr(2, 300, 200, 20, 20, 1'b1);
    rom_const[2] = 8'h03;
    set_pix(0, 0, 8'h55);
    tick();
    checks++; if (coll !== 7'b0000001) begin errors++; $display("FAIL coll_prev_frame: got %b want 0000001", coll); end
    else $display("ok coll_prev_frame %b", coll);
    run_pixel(305, 205, 8'hAA);
    checks++; if (rgb !== 8'hE0) begin errors++; $display("FAIL coll_rgb: got %h want e0", rgb); end
    else $display("ok coll_rgb e0");
    set_pix(0, 0, 8'h55);
    tick();
    checks++; if (coll !== 7'b0000010) begin errors++; $display("FAIL coll_s2: got %b want 0000010", coll); end
    else $display("ok coll_s2 %b", coll);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL coll_fd: got %b want 1", frame_done); end
    else $display("ok coll_fd");
    set_fill();
    tick();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL coll_fd_pulse: got %b want 0", frame_done); end
    else $display("ok coll_fd_pulse");
    // overlap reaches the final stage on the very clock of the latch
    set_pix(305, 205, 8'hAA);
    tick();
    set_fill();
    tick();
    set_pix(0, 0, 8'h55);
    tick();
    checks++; if (coll !== 7'b0) begin errors++; $display("FAIL coll_sameclk_old: got %b want 0", coll); end
    else $display("ok coll_sameclk_old");
    sx[2] = CW'(500);
    set_fill();
    tick();
    tick();
    set_pix(0, 0, 8'h55);
    tick();
    checks++; if (coll !== 7'b0000010) begin errors++; $display("FAIL coll_sameclk_kept: got %b want 0000010", coll); end
    else $display("ok coll_sameclk_kept %b", coll);
    run_pixel(305, 205, 8'hAA);
    set_pix(0, 0, 8'h55);
    tick();
    checks++; if (coll !== 7'b0) begin errors++; $display("FAIL coll_cleared: got %b want 0", coll); end
    else $display("ok coll_cleared");
  endtask

  task automatic test_boundary();
    sen = '0;
    set_spr(3, 1016, 10, 30, 20, 1'b1);
    rom_const[3] = 8'h1F;
    set_pix(0, 0, 8'h55);
    tick();
    for (int h = 0; h < 16; h++) begin
      set_pix(h, 15, 8'hAA);
      tick();
      checks++; if (rom_addr[3*AW +: AW] !== 15'd0) begin errors++; $display("FAIL wrap_addr hc=%0d: got %0d want 0", h, rom_addr[3*AW +: AW]); end
      else $display("ok wrap_addr hc=%0d", h);
    end
    set_fill();
    tick();
    tick();
    checks++; if (rgb !== 8'hAA) begin errors++; $display("FAIL wrap_rgb: got %h want aa", rgb); end
    else $display("ok wrap_rgb aa");
    set_pix(1020, 15, 8'hAA);
    tick();
    checks++; if (rom_addr[3*AW +: AW] !== 15'd154) begin errors++; $display("FAIL edge_hit_addr: got %0d want 154", rom_addr[3*AW +: AW]); end
    else $display("ok edge_hit_addr 154");
    set_fill();
    tick();
    tick();
    checks++; if (rgb !== BORDER_C) begin errors++; $display("FAIL border_sprite: got %h want %h", rgb, BORDER_C); end
    else $display("ok border_sprite");
    run_pixel(640, 100, 8'hAA);
    checks++; if (rgb !== BORDER_C) begin errors++; $display("FAIL border_x1: got %h want %h", rgb, BORDER_C); end
    else $display("ok border_x1");
    run_pixel(639, 100, 8'hAA);
    checks++; if (rgb !== 8'hAA) begin errors++; $display("FAIL inside_x1m1: got %h want aa", rgb); end
    else $display("ok inside_x1m1");
    video_on = 1'b0;
    set_pix(639, 100, 8'hAA);
    tick();
    video_on = 1'b1;
    set_fill();
    tick();
    tick();
    checks++; if (rgb !== 8'h00) begin errors++; $display("FAIL video_off: got %h want 00", rgb); end
    else $display("ok video_off");
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    video_on = 1'b1;
    wx0 = CW'(0);
    wx1 = CW'(640);
    wy0 = CW'(0);
    wy1 = CW'(480);
    sen   = '0;
    sanim = '0;
    for (int i = 0; i < N; i++) begin
      sx[i] = '0;
      sy[i] = '0;
      sw[i] = '0;
      sh[i] = '0;
      rom_const[i]    = 8'h00;
      rom_use_addr[i] = 1'b0;
    end
    set_pix(215, 110, 8'hAA);
    test_reset();
    test_basic();
    test_anim();
    test_priority();
    test_collision();
    test_boundary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
